// File: rtl/pipe_pkg.sv
// Shared widths and NOP encoding for the inter-stage pipeline registers.
// The default IF/ID payload is {PC+4, instruction}.
package pipe_pkg;

    localparam int unsigned INSN_W = 32;
    localparam int unsigned PC_W   = 32;

    localparam logic [INSN_W-1:0] MIPS_NOP       = 32'h0000_0000;
    localparam logic [PC_W-1:0]   PC_RESET_PLUS4 = 32'h0000_0004;

    localparam int unsigned IF_ID_W = PC_W + INSN_W;

    // Word seen downstream on reset, flush and bubbles for an IF/ID latch.
    function automatic logic [IF_ID_W-1:0] if_id_nop();
        return {PC_RESET_PLUS4, MIPS_NOP};
    endfunction

endpackage

// File: rtl/pipe_sat_ctr.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module pipe_sat_ctr #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear wins, otherwise step unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake.
// SKID=1: two-entry skid buffer, in_ready comes straight from a flop.
// SKID=0: single register, in_ready = !main_v || out_ready.
// Flush and reset load NOP_DATA; bubbles present NOP_DATA on out_data.
// Optional macro PIPE_SKID_STAT_EN adds stall/flush statistics counters.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned        DATA_W   = IF_ID_W,
    parameter logic [DATA_W-1:0]  NOP_DATA = DATA_W'(if_id_nop()),
    parameter bit                 SKID     = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_SKID_STAT_EN
    ,
    output logic [31:0]       stat_stall,
    output logic [15:0]       stat_flush
`endif
);

    logic              main_v_q, main_v_d;
    logic [DATA_W-1:0] main_d_q, main_d_d;
    logic              skid_v_q, skid_v_d;
    logic [DATA_W-1:0] skid_d_q, skid_d_d;

    logic in_fire;
    logic pop;

    // Upstream handshake: registered for the skid variant, combinational otherwise.
    always_comb begin
        if (SKID) begin
            in_ready = !skid_v_q;
        end else begin
            in_ready = !main_v_q || out_ready;
        end
    end

    assign in_fire = in_valid && in_ready;
    assign pop     = main_v_q && out_ready;

    // Next-state for main/skid entries; flush overrides every transfer.
    always_comb begin
        main_v_d = main_v_q;
        main_d_d = main_d_q;
        skid_v_d = skid_v_q;
        skid_d_d = skid_d_q;
        if (flush) begin
            main_v_d = 1'b0;
            main_d_d = NOP_DATA;
            skid_v_d = 1'b0;
            skid_d_d = NOP_DATA;
        end else if (SKID) begin
            if (pop) begin
                if (skid_v_q) begin
                    // in_ready is low here, so no push can coincide.
                    main_v_d = 1'b1;
                    main_d_d = skid_d_q;
                    skid_v_d = 1'b0;
                end else if (in_fire) begin
                    main_v_d = 1'b1;
                    main_d_d = in_data;
                end else begin
                    main_v_d = 1'b0;
                end
            end else if (in_fire) begin
                if (!main_v_q) begin
                    main_v_d = 1'b1;
                    main_d_d = in_data;
                end else begin
                    skid_v_d = 1'b1;
                    skid_d_d = in_data;
                end
            end
        end else begin
            if (in_fire) begin
                main_v_d = 1'b1;
                main_d_d = in_data;
            end else if (pop) begin
                main_v_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset to an empty, NOP-filled stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_v_q <= 1'b0;
            main_d_q <= NOP_DATA;
            skid_v_q <= 1'b0;
            skid_d_q <= NOP_DATA;
        end else begin
            main_v_q <= main_v_d;
            main_d_q <= main_d_d;
            skid_v_q <= skid_v_d;
            skid_d_q <= skid_d_d;
        end
    end

    assign out_valid = main_v_q;
    assign out_data  = main_v_q ? main_d_q : NOP_DATA;

`ifdef PIPE_SKID_STAT_EN
    pipe_sat_ctr #(
        .WIDTH(32)
    ) u_stat_stall (
        .clk   (clk),
        .clr_i (reset),
        .inc_i (main_v_q && !out_ready),
        .cnt_o (stat_stall)
    );

    pipe_sat_ctr #(
        .WIDTH(16)
    ) u_stat_flush (
        .clk   (clk),
        .clr_i (reset),
        .inc_i (flush),
        .cnt_o (stat_flush)
    );
`endif

endmodule
